// File: rtl/i2c_cmd_queue.sv
// rtl/i2c_cmd_queue.sv - filtered C&C command FIFO feeding i2c_bus2 with ack-checked replay and backoff
module i2c_cmd_queue #(
  parameter int DEPTH          = 8,
  parameter int BACKOFF_CYCLES = 64,
  parameter int MAX_RETRY      = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               in_addr,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  output logic [5:0]               ds_addr,
  output logic [31:0]              ds_data,
  output logic                     ds_rqst,
  input  logic                     ds_ack,
  input  logic                     ds_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     retry_fail,
  output logic [7:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BACKOFF_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [LW-1:0] FULL_LEVEL   = LW'(DEPTH);
  localparam logic [BW-1:0] BACKOFF_LOAD = BW'(BACKOFF_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, BACKOFF} state_t;
  state_t state, next_state;

  logic [37:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [6:0]    last_filter;
  logic [RW-1:0] retries;
  logic [BW-1:0] backoff_cnt;

  logic rule_a, rule_b, push_req, full, push, push_drop, pop;
  logic launch, pop_ack, pop_discard, start_backoff;
  logic [8:0] drop_sum;

  always_comb begin
    rule_a    = (in_addr == 6'h3c || in_addr == 6'h3d) && in_data[31:24] == 8'h06;
    rule_b    = (in_addr == 6'h00) && (in_data[23:17] != last_filter);
    push_req  = in_valid && (rule_a || rule_b);
    full      = (level == FULL_LEVEL);
    pop       = pop_ack || pop_discard;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    push      = push_req && (!full || pop);
    push_drop = push_req && full && !pop;
    drop_sum  = {1'b0, drop_count} + {8'b0, push_drop} + {8'b0, pop_discard};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    ds_rqst       = 1'b0;
    launch        = 1'b0;
    pop_ack       = 1'b0;
    pop_discard   = 1'b0;
    start_backoff = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0 && ds_ready) begin
          launch     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        ds_rqst    = 1'b1;
        next_state = CHECK;
      end
      CHECK: begin
        if (ds_ack) begin
          pop_ack    = 1'b1;
          next_state = IDLE;
        end else if (retries == RETRY_LAST) begin
          pop_discard = 1'b1;
          next_state  = IDLE;
        end else begin
          start_backoff = 1'b1;
          next_state    = BACKOFF;
        end
      end
      BACKOFF: begin
        if (backoff_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_addr, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      last_filter <= '0;
      overflow    <= 1'b0;
      retry_fail  <= 1'b0;
      drop_count  <= '0;
      retries     <= '0;
      backoff_cnt <= '0;
      ds_addr     <= '0;
      ds_data     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // only a committed filter change is remembered, so a dropped one is retried
      if (push && rule_b) last_filter <= in_data[23:17];
      if (push_drop)      overflow    <= 1'b1;
      if (pop_discard)    retry_fail  <= 1'b1;
      drop_count <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      if (start_backoff) retries <= retries + RW'(1);
      else if (pop)      retries <= '0;
      if (start_backoff)                            backoff_cnt <= BACKOFF_LOAD;
      else if (state == BACKOFF && backoff_cnt != '0) backoff_cnt <= backoff_cnt - BW'(1);
      if (launch) {ds_addr, ds_data} <= mem[rd_ptr];
    end
  end
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// tb/tb_i2c_cmd_queue.sv - directed, table-driven bench for i2c_cmd_queue
module tb_i2c_cmd_queue;
  localparam int DEPTH   = 8;
  localparam int BACKOFF = 64;
  localparam int MAXR    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [5:0]  ds_addr;
  logic [31:0] ds_data;
  logic        ds_rqst;
  logic        ds_ack;
  logic        ds_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic        overflow, retry_fail;
  logic [7:0]  drop_count;

  i2c_cmd_queue #(.DEPTH(DEPTH), .BACKOFF_CYCLES(BACKOFF), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid),
    .ds_addr(ds_addr), .ds_data(ds_data), .ds_rqst(ds_rqst), .ds_ack(ds_ack),
    .ds_ready(ds_ready), .level(level), .overflow(overflow), .retry_fail(retry_fail),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // downstream model: acks the cycle after each request according to the policy
  int  nack_left = 0;
  bit  ack_never = 1'b0;
  bit  pend_req  = 1'b0;
  bit  pend_ack  = 1'b0;
  int          rq_cyc[$];
  logic [5:0]  rq_addr[$];
  logic [31:0] rq_data[$];

  initial begin
    ds_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      ds_ack   = pend_req ? pend_ack : 1'b0;
      pend_req = ds_rqst;
      if (ds_rqst) begin
        if (ack_never) pend_ack = 1'b0;
        else if (nack_left > 0) begin pend_ack = 1'b0; nack_left--; end
        else pend_ack = 1'b1;
        rq_cyc.push_back(cyc);
        rq_addr.push_back(ds_addr);
        rq_data.push_back(ds_data);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic step_to(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin step(); guard++; end
  endtask

  task automatic wait_rq(input int n, input int budget, input string name);
    int k = 0;
    while (rq_data.size() < n && k < budget) begin step(); k++; end
    checks++;
    if (rq_data.size() < n) begin
      errors++;
      $display("FAIL %s: got %0d requests expected %0d", name, rq_data.size(), n);
    end
  endtask

  task automatic clear_log();
    rq_cyc.delete(); rq_addr.delete(); rq_data.delete();
  endtask

  task automatic push_word(input logic [5:0] a, input logic [31:0] d);
    in_addr = a; in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  exp_level;
  } fvec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } dvec_t;

  fvec_t fv[12];
  dvec_t dv[4];

  initial begin
    int n0, m;

    fv[0]  = '{6'h00, 32'h000A_0000, 4'd1};
    fv[1]  = '{6'h00, 32'h000A_0000, 4'd1};
    fv[2]  = '{6'h00, 32'h000A_1234, 4'd1};
    fv[3]  = '{6'h00, 32'hFF0B_0000, 4'd1};
    fv[4]  = '{6'h00, 32'h000A_0000, 4'd1};
    fv[5]  = '{6'h00, 32'h0012_0000, 4'd2};
    fv[6]  = '{6'h12, 32'h0600_0000, 4'd2};
    fv[7]  = '{6'h3c, 32'h06AA_BBCC, 4'd3};
    fv[8]  = '{6'h3d, 32'h0711_2233, 4'd3};
    fv[9]  = '{6'h00, 32'h0000_0000, 4'd4};
    fv[10] = '{6'h00, 32'h0001_FFFF, 4'd4};
    fv[11] = '{6'h3e, 32'h0600_0000, 4'd4};
    dv[0]  = '{6'h00, 32'h000A_0000};
    dv[1]  = '{6'h00, 32'h0012_0000};
    dv[2]  = '{6'h3c, 32'h06AA_BBCC};
    dv[3]  = '{6'h00, 32'h0000_0000};

    do_reset();
    chk("reset_level", level, 0);
    chk("reset_rqst", ds_rqst, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_retry_fail", retry_fail, 0);
    chk("reset_drop_count", drop_count, 0);
    chk("reset_ds_addr", ds_addr, 0);
    chk("reset_ds_data", ds_data, 0);

    // single write, latency and pop timing
    ds_ready = 1'b1;
    clear_log();
    n0 = cyc;
    push_word(6'h3d, 32'h061A_2233);
    wait_rq(1, 20, "single_rqst");
    if (rq_data.size() >= 1) begin
      chk("single_rqst_cycle", rq_cyc[0] - n0, 2);
      chk("single_data", rq_data[0], 32'h061A_2233);
      chk("single_addr", rq_addr[0], 6'h3d);
    end
    step_to(n0 + 3);
    chk("single_level_before_pop", level, 1);
    step_to(n0 + 4);
    chk("single_level_after_pop", level, 0);
    step_to(n0 + 20);
    chk("single_one_rqst", rq_data.size(), 1);

    // filter and dedupe table, held in the FIFO
    ds_ready = 1'b0;
    clear_log();
    foreach (fv[i]) begin
      push_word(fv[i].addr, fv[i].data);
      chk($sformatf("filter_level_%0d", i), level, fv[i].exp_level);
    end
    ds_ready = 1'b1;
    wait_rq(4, 80, "filter_drain");
    step_to(cyc + 10);
    chk("filter_drain_count", rq_data.size(), 4);
    foreach (dv[i]) begin
      if (rq_data.size() > i) begin
        chk($sformatf("filter_drain_addr_%0d", i), rq_addr[i], dv[i].addr);
        chk($sformatf("filter_drain_data_%0d", i), rq_data[i], dv[i].data);
      end
    end
    chk("filter_level_empty", level, 0);

    // two missed acks then success
    clear_log();
    nack_left = 2;
    push_word(6'h3c, 32'h0600_0001);
    wait_rq(3, 400, "retry_rqst");
    step_to(cyc + 10);
    chk("retry_count", rq_data.size(), 3);
    if (rq_data.size() >= 3) begin
      chk("retry_gap_0", rq_cyc[1] - rq_cyc[0], 2 + BACKOFF + 1);
      chk("retry_gap_1", rq_cyc[2] - rq_cyc[1], 2 + BACKOFF + 1);
      chk("retry_same_data_1", rq_data[1], 32'h0600_0001);
      chk("retry_same_data_2", rq_data[2], 32'h0600_0001);
    end
    chk("retry_level", level, 0);
    chk("retry_no_fail", retry_fail, 0);

    // retry exhaustion, then the next entry goes out
    clear_log();
    ack_never = 1'b1;
    push_word(6'h3c, 32'h0600_0011);
    push_word(6'h3d, 32'h0600_0022);
    wait_rq(MAXR, MAXR * (BACKOFF + 3) + 50, "exhaust_rqst");
    ack_never = 1'b0;
    for (int i = 0; i < MAXR; i++)
      if (rq_data.size() > i) chk($sformatf("exhaust_data_%0d", i), rq_data[i], 32'h0600_0011);
    wait_rq(MAXR + 1, 20, "exhaust_next");
    step_to(cyc + 5);
    if (rq_data.size() > MAXR) chk("exhaust_next_data", rq_data[MAXR], 32'h0600_0022);
    chk("exhaust_retry_fail", retry_fail, 1);
    chk("exhaust_drop_count", drop_count, 1);
    chk("exhaust_level", level, 0);

    // overflow: DEPTH+3 pushes while stalled
    do_reset();
    ds_ready = 1'b0;
    clear_log();
    for (int i = 0; i < DEPTH + 3; i++) push_word(6'h3c, 32'h0600_0100 + i);
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_count", drop_count, 3);
    step_to(cyc + 20);
    chk("ovf_stall_no_rqst", rq_data.size(), 0);
    ds_ready = 1'b1;
    wait_rq(DEPTH, DEPTH * 6 + 20, "ovf_drain");
    step_to(cyc + 10);
    chk("ovf_drain_count", rq_data.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (rq_data.size() > i) chk($sformatf("ovf_order_%0d", i), rq_data[i], 32'h0600_0100 + i);
    chk("ovf_level_empty", level, 0);

    // reset in the middle of backoff
    ds_ready = 1'b0;
    ack_never = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) push_word(6'h3d, 32'h0600_0200 + i);
    ds_ready = 1'b1;
    wait_rq(1, 20, "midrst_rqst");
    m = (rq_cyc.size() > 0) ? rq_cyc[0] : cyc;
    step_to(m + 10);
    chk("midrst_level_before", level, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_rqst", ds_rqst, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_retry_fail", retry_fail, 0);
    chk("midrst_drop_count", drop_count, 0);
    clear_log();
    step_to(cyc + 200);
    chk("midrst_no_rqst", rq_data.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
